// File: rtl/bmp_pkg.sv
// Shared types and constants for the BMP pixel reader.
// The RGB565 word layout and the filter modes are used by both the top and the filter.
package bmp_pkg;

    typedef enum logic [1:0] {
        PASS   = 2'b00,
        GRAY   = 2'b01,
        INVERT = 2'b10,
        RSVD   = 2'b11
    } filter_mode_t;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    localparam int LAT           = 3;
    localparam int IMG_W_DEFAULT = 320;
    localparam int IMG_H_DEFAULT = 240;

endpackage

// File: rtl/bmp_pixel_reader_filter.sv
// Combinational colour filter: RGB565 word plus mode to 12-bit VGA colour.
// Anything outside the active image (blanking or border) is forced to black.
module pixel_filter
    import bmp_pkg::*;
(
    input  logic [15:0] pixel,
    input  logic [1:0]  mode,
    input  logic        de,
    input  logic        in_win,
    output logic [11:0] rgb
);

    rgb565_t    px;
    logic [7:0] r8;
    logic [7:0] g8;
    logic [7:0] b8;
    logic [9:0] luma;
    logic [3:0] gray;
    logic [3:0] pr;
    logic [3:0] pg;
    logic [3:0] pb;

    assign px = rgb565_t'(pixel);

    always_comb begin
        // Replicate the high bits into the low bits so full scale maps to 8'hFF.
        r8   = {px.r, px.r[4:2]};
        g8   = {px.g, px.g[5:4]};
        b8   = {px.b, px.b[4:2]};
        luma = {2'b00, r8} + {1'b0, g8, 1'b0} + {2'b00, b8};
        gray = 4'(luma >> 6);
        pr   = px.r[4:1];
        pg   = px.g[5:2];
        pb   = px.b[4:1];
        rgb  = '0;
        if (de && in_win) begin
            case (filter_mode_t'(mode))
                GRAY:    rgb = {gray, gray, gray};
                INVERT:  rgb = ~{pr, pg, pb};
                default: rgb = {pr, pg, pb};
            endcase
        end
    end

endmodule

// File: rtl/bmp_pixel_reader.sv
// Reads a 2x upscaled RGB565 image from an external synchronous ROM in step with
// the VGA sync stream and outputs filtered 4-bit colour with syncs delayed to match.
module bmp_pixel_reader
    import bmp_pkg::*;
#(
    parameter int IMG_W  = IMG_W_DEFAULT,
    parameter int IMG_H  = IMG_H_DEFAULT,
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              h_sync_in,
    input  logic              v_sync_in,
    input  logic              de_in,
    input  logic [9:0]        pixel_x,
    input  logic [9:0]        pixel_y,
    input  logic [1:0]        mode_sel,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    output logic              h_sync,
    output logic              v_sync,
    output logic              DE,
    output logic [3:0]        red,
    output logic [3:0]        green,
    output logic [3:0]        blue,
    output logic              frame_start
);

    localparam logic [10:0] X_LIM  = 11'(2 * IMG_W);
    localparam logic [10:0] Y_LIM  = 11'(2 * IMG_H);
    localparam int          W_BITS = $clog2(IMG_W + 1);

    logic [8:0]        sx;
    logic [8:0]        sy;
    logic [ADDR_W-1:0] addr_next;
    logic [ADDR_W-1:0] rom_addr_reg;
    logic              in_win_next;
    logic              in_win1_reg;
    logic              in_win2_reg;
    logic [LAT-1:0]    hs_tap_reg;
    logic [LAT-1:0]    vs_tap_reg;
    logic [LAT-1:0]    de_tap_reg;
    logic [11:0]       rgb_next;
    logic [11:0]       rgb_reg;
    logic              vs_prev_reg;
    logic              vs_fall;
    logic              frame_start_reg;
    filter_mode_t      active_mode_reg;

    assign sx          = pixel_x[9:1];
    assign sy          = pixel_y[9:1];
    assign in_win_next = de_in && ({1'b0, pixel_x} < X_LIM) && ({1'b0, pixel_y} < Y_LIM);

    // Constant multiply by IMG_W as a sum of shifted copies of sy.
    always_comb begin
        addr_next = ADDR_W'(sx);
        for (int i = 0; i < W_BITS; i++) begin
            if (IMG_W[i]) begin
                addr_next = addr_next + (ADDR_W'(sy) << i);
            end
        end
    end

    // S1 address, S2 slot while the ROM reads, S3 output register.
    always_ff @(posedge clk) begin
        if (reset) begin
            rom_addr_reg <= '0;
            in_win1_reg  <= 1'b0;
            in_win2_reg  <= 1'b0;
            hs_tap_reg   <= '1;
            vs_tap_reg   <= '1;
            de_tap_reg   <= '0;
            rgb_reg      <= '0;
        end else begin
            if (in_win_next) begin
                rom_addr_reg <= addr_next;
            end
            in_win1_reg <= in_win_next;
            in_win2_reg <= in_win1_reg;
            hs_tap_reg  <= {hs_tap_reg[LAT-2:0], h_sync_in};
            vs_tap_reg  <= {vs_tap_reg[LAT-2:0], v_sync_in};
            de_tap_reg  <= {de_tap_reg[LAT-2:0], de_in};
            rgb_reg     <= rgb_next;
        end
    end

    // The filter mode only changes at a frame boundary (v_sync_in falling edge).
    assign vs_fall = vs_prev_reg && !v_sync_in;

    always_ff @(posedge clk) begin
        if (reset) begin
            vs_prev_reg     <= 1'b1;
            active_mode_reg <= PASS;
            frame_start_reg <= 1'b0;
        end else begin
            vs_prev_reg     <= v_sync_in;
            frame_start_reg <= vs_fall;
            if (vs_fall) begin
                active_mode_reg <= filter_mode_t'(mode_sel);
            end
        end
    end

    pixel_filter u_filter (
        .pixel  (rom_data),
        .mode   (active_mode_reg),
        .de     (de_tap_reg[LAT-2]),
        .in_win (in_win2_reg),
        .rgb    (rgb_next)
    );

    assign rom_addr    = rom_addr_reg;
    assign h_sync      = hs_tap_reg[LAT-1];
    assign v_sync      = vs_tap_reg[LAT-1];
    assign DE          = de_tap_reg[LAT-1];
    assign red         = rgb_reg[11:8];
    assign green       = rgb_reg[7:4];
    assign blue        = rgb_reg[3:0];
    assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_bmp_pixel_reader.sv
// Randomized bench for bmp_pixel_reader: a full-size and a reduced-window instance
// share one input stream and are compared every cycle against a per-pixel reference model.
module tb_bmp_pixel_reader;

    localparam int FW   = 320;
    localparam int FH   = 240;
    localparam int SW   = 160;
    localparam int SH   = 120;
    localparam int MAXC = 8192;

    typedef struct {
        bit rst;
        bit hs;
        bit vs;
        bit de;
        int x;
        int y;
        int mode;
        bit fall;
    } rec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        h_sync_in;
    logic        v_sync_in;
    logic        de_in;
    logic [9:0]  pixel_x;
    logic [9:0]  pixel_y;
    logic [1:0]  mode_sel;

    logic [16:0] rom_addr_a, rom_addr_b;
    logic [15:0] rom_data_a, rom_data_b;
    logic        h_sync_a, v_sync_a, de_a, fs_a;
    logic        h_sync_b, v_sync_b, de_b, fs_b;
    logic [3:0]  red_a, green_a, blue_a;
    logic [3:0]  red_b, green_b, blue_b;

    rec_t hist [0:MAXC-1];
    int   cyc = 0;
    int   frame_mode = 0;
    int   addr_a = 0;
    int   addr_b = 0;
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    bmp_pixel_reader u_dut_a (
        .clk (clk), .reset (reset),
        .h_sync_in (h_sync_in), .v_sync_in (v_sync_in), .de_in (de_in),
        .pixel_x (pixel_x), .pixel_y (pixel_y), .mode_sel (mode_sel),
        .rom_addr (rom_addr_a), .rom_data (rom_data_a),
        .h_sync (h_sync_a), .v_sync (v_sync_a), .DE (de_a),
        .red (red_a), .green (green_a), .blue (blue_a),
        .frame_start (fs_a)
    );

    bmp_pixel_reader #(.IMG_W(SW), .IMG_H(SH), .ADDR_W(17)) u_dut_b (
        .clk (clk), .reset (reset),
        .h_sync_in (h_sync_in), .v_sync_in (v_sync_in), .de_in (de_in),
        .pixel_x (pixel_x), .pixel_y (pixel_y), .mode_sel (mode_sel),
        .rom_addr (rom_addr_b), .rom_data (rom_data_b),
        .h_sync (h_sync_b), .v_sync (v_sync_b), .DE (de_b),
        .red (red_b), .green (green_b), .blue (blue_b),
        .frame_start (fs_b)
    );

    // Image content: address as data, with a white and a pure-red pixel planted.
    function automatic logic [15:0] rom_word(input logic [16:0] a);
        if (a == 17'd1000) return 16'hFFFF;
        if (a == 17'd1001) return 16'hF800;
        return a[15:0];
    endfunction

    always @(posedge clk) begin
        rom_data_a <= rom_word(rom_addr_a);
        rom_data_b <= rom_word(rom_addr_b);
    end

    function automatic int exp_rgb(input rec_t r, input int w, input int h);
        int word, r5, g6, b5, pr, pg, pb, r8, g8, b8, yv;
        if (!r.de || r.x >= 2 * w || r.y >= 2 * h) return 0;
        word = int'(rom_word(17'((r.y / 2) * w + r.x / 2)));
        r5 = word / 2048;
        g6 = (word / 32) % 64;
        b5 = word % 32;
        pr = r5 / 2;
        pg = g6 / 4;
        pb = b5 / 2;
        if (r.mode == 1) begin
            r8 = r5 * 8 + r5 / 4;
            g8 = g6 * 4 + g6 / 16;
            b8 = b5 * 8 + b5 / 4;
            yv = (r8 + 2 * g8 + b8) / 64;
            return yv * 273;
        end
        if (r.mode == 2) return (15 - pr) * 256 + (15 - pg) * 16 + (15 - pb);
        return pr * 256 + pg * 16 + pb;
    endfunction

    function automatic bit squashed(input int n);
        for (int k = n - 3; k <= n - 1; k++) begin
            if (k < 0 || hist[k].rst) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic check_eq(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic check_outputs();
        rec_t rr;
        int   ehs, evs, ede, ea, eb, efs;
        if (squashed(cyc)) begin
            ehs = 1; evs = 1; ede = 0; ea = 0; eb = 0;
        end else begin
            rr  = hist[cyc - 3];
            ehs = int'(rr.hs);
            evs = int'(rr.vs);
            ede = int'(rr.de);
            ea  = exp_rgb(rr, FW, FH);
            eb  = exp_rgb(rr, SW, SH);
        end
        efs = (cyc >= 1 && hist[cyc - 1].fall) ? 1 : 0;
        check_eq("h_sync_a", int'(h_sync_a), ehs);
        check_eq("v_sync_a", int'(v_sync_a), evs);
        check_eq("de_a", int'(de_a), ede);
        check_eq("rgb_a", int'({red_a, green_a, blue_a}), ea);
        check_eq("frame_start_a", int'(fs_a), efs);
        check_eq("rom_addr_a", int'(rom_addr_a), addr_a);
        check_eq("h_sync_b", int'(h_sync_b), ehs);
        check_eq("v_sync_b", int'(v_sync_b), evs);
        check_eq("de_b", int'(de_b), ede);
        check_eq("rgb_b", int'({red_b, green_b, blue_b}), eb);
        check_eq("frame_start_b", int'(fs_b), efs);
        check_eq("rom_addr_b", int'(rom_addr_b), addr_b);
    endtask

    task automatic step(input bit rst, input bit hs, input bit vs, input bit de,
                        input int x, input int y);
        rec_t r;
        bit   vs_before;
        if (cyc >= MAXC) begin
            $display("FAIL history_overflow cyc=%0d got=%0d exp=<%0d", cyc, cyc, MAXC);
            $fatal(1, "history overflow");
        end
        vs_before = (cyc == 0) ? 1'b1 : (hist[cyc - 1].rst ? 1'b1 : hist[cyc - 1].vs);
        r.rst  = rst;
        r.hs   = hs;
        r.vs   = vs;
        r.de   = de;
        r.x    = x;
        r.y    = y;
        r.fall = !rst && !vs && vs_before;
        if (rst) frame_mode = 0;
        else if (r.fall) frame_mode = (mode_sel == 2'b11) ? 0 : int'(mode_sel);
        r.mode = frame_mode;
        hist[cyc] = r;
        reset     = rst;
        h_sync_in = hs;
        v_sync_in = vs;
        de_in     = de;
        pixel_x   = 10'(x);
        pixel_y   = 10'(y);
        @(posedge clk);
        #1;
        if (rst) begin
            addr_a = 0;
            addr_b = 0;
        end else if (de) begin
            if (x < 2 * FW && y < 2 * FH) addr_a = (y / 2) * FW + x / 2;
            if (x < 2 * SW && y < 2 * SH) addr_b = (y / 2) * SW + x / 2;
        end
        cyc++;
        check_outputs();
    endtask

    task automatic blank(input int n, input bit hs, input bit vs);
        for (int i = 0; i < n; i++) begin
            step(1'b0, hs, vs, 1'b0, int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)));
        end
    endtask

    task automatic scan_line(input int y, input int x0, input int len, input int rst_x);
        blank(4, 1'b0, 1'b1);
        blank(3, 1'b1, 1'b1);
        for (int i = 0; i < len; i++) begin
            step((x0 + i) == rst_x, 1'b1, 1'b1, 1'b1, x0 + i, y);
        end
        blank(3, 1'b1, 1'b1);
        $display("line y=%0d x=%0d..%0d mode_sel=%0d frame_mode=%0d", y, x0, x0 + len - 1,
                 mode_sel, frame_mode);
    endtask

    task automatic vsync_block();
        for (int l = 0; l < 2; l++) begin
            blank(4, 1'b0, 1'b0);
            blank(22, 1'b1, 1'b0);
        end
        blank(4, 1'b0, 1'b1);
        blank(22, 1'b1, 1'b1);
        $display("vsync mode_sel=%0d frame_mode=%0d", mode_sel, frame_mode);
    endtask

    task automatic random_lines(input int n);
        for (int i = 0; i < n; i++) begin
            scan_line(int'($urandom_range(0, 479)), int'($urandom_range(0, 640 - 16)), 16, -1);
        end
    endtask

    task automatic directed_lines();
        scan_line(3, 0, 9, -1);
        scan_line(6, 76, 10, -1);
        scan_line(1, 630, 10, -1);
        scan_line(2, 0, 4, -1);
        scan_line(239, 316, 8, -1);
        scan_line(240, 316, 8, -1);
    endtask

    initial begin
        mode_sel = 2'b00;
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 0, 0);
        $display("reset applied");

        // Pass frame; mode request changes mid-frame and must wait for vsync.
        vsync_block();
        directed_lines();
        mode_sel = 2'b10;
        random_lines(3);
        scan_line(6, 76, 10, -1);

        vsync_block();
        directed_lines();
        random_lines(3);

        mode_sel = 2'b01;
        vsync_block();
        directed_lines();
        random_lines(3);

        // Reset mid-line falls back to pass for the rest of the frame.
        mode_sel = 2'b10;
        vsync_block();
        scan_line(6, 76, 10, -1);
        scan_line(50, 90, 20, 100);
        scan_line(6, 76, 10, -1);
        random_lines(2);

        mode_sel = 2'b11;
        vsync_block();
        directed_lines();
        random_lines(2);

        for (int f = 0; f < 3; f++) begin
            mode_sel = 2'($urandom_range(0, 3));
            vsync_block();
            scan_line(6, 76, 10, -1);
            mode_sel = 2'($urandom_range(0, 3));
            random_lines(4);
        end
        blank(6, 1'b1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
